vx_csr_pending_tracker: RTL and testbench

Scheduler-side responder for the scheduler/CSR interface. It keeps one in-flight instruction counter per warp and answers the CSR unit's almost-empty query for the requesting warp. It locks a warp when an FPU-CSR instruction issues and releases it on the CSR unit's unlock. It also maintains the free-running cycle counter exported to the CSR unit. It sits in the scheduler, between the issue/commit paths and the sched_csr_if slave in the CSR unit.

---
 rtl/vx_csr_pending_tracker_pkg.sv | 17 +
 rtl/vx_csr_pending_tracker_counter.sv | 34 +++
 rtl/vx_csr_pending_tracker.sv | 106 ++++++++++
 tb/tb_vx_csr_pending_tracker.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_csr_pending_tracker_pkg.sv
// Shared types and constants for the scheduler-side CSR pending tracker.
// Per-warp state pairs the in-flight instruction count with the FPU-CSR lock bit.
package vx_csr_pending_tracker_pkg;

    localparam int PENDING_SIZE_DEF = 16;
    localparam int PENDING_BITS     = $clog2(PENDING_SIZE_DEF + 1);

    typedef struct packed {
        logic [PENDING_BITS-1:0] count;
        logic                    locked;
    } warp_state_t;

    function automatic int nw_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_csr_pending_tracker_counter.sv
// Up/down saturating in-flight counter for one warp.
// Flags when the counter is full and when exactly one instruction remains.
module vx_csr_pending_tracker_counter
    import vx_csr_pending_tracker_pkg::*;
#(
    parameter int SIZE = PENDING_SIZE_DEF,
    parameter int W    = PENDING_BITS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full,
    output logic         one
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + W'(1);
        end else if (dec && !inc && (count != '0)) begin
            // A decrement at zero is a stray commit; the counter holds at zero.
            count <= count - W'(1);
        end
    end

    always_comb begin
        full = (count == W'(SIZE));
        one  = (count == W'(1));
    end

endmodule

// File: rtl/vx_csr_pending_tracker.sv
// Scheduler-side responder to the CSR unit: per-warp in-flight counts,
// almost-empty query, FPU-CSR warp locks and the free-running cycle counter.
module vx_csr_pending_tracker
    import vx_csr_pending_tracker_pkg::*;
#(
    parameter int NUM_WARPS    = 8,
    parameter int PENDING_SIZE = PENDING_SIZE_DEF,
    parameter int CYCLE_WIDTH  = 64,
    parameter int NW_WIDTH     = nw_width(NUM_WARPS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic [NW_WIDTH-1:0]    issue_wid,
    input  logic                   issue_lock,
    input  logic                   commit_valid,
    input  logic                   commit_eop,
    input  logic [NW_WIDTH-1:0]    commit_wid,
    input  logic [NW_WIDTH-1:0]    alm_empty_wid,
    output logic                   alm_empty,
    input  logic                   unlock_warp,
    input  logic [NW_WIDTH-1:0]    unlock_wid,
    output logic [NUM_WARPS-1:0]   warp_locked,
    output logic [CYCLE_WIDTH-1:0] cycles
);

    logic [NUM_WARPS-1:0]    cnt_full;
    logic [NUM_WARPS-1:0]    cnt_one;
    logic [NUM_WARPS-1:0]    lock_set;
    logic [NUM_WARPS-1:0]    lock_clr;
    logic [NUM_WARPS-1:0]    locked_q;
    logic [PENDING_BITS-1:0] cnt [NUM_WARPS];
    warp_state_t             warp_state [NUM_WARPS];
    logic                    issue_fire;
    logic [CYCLE_WIDTH-1:0]  cycles_q;

    for (genvar g = 0; g < NUM_WARPS; g++) begin : g_warp
        vx_csr_pending_tracker_counter #(
            .SIZE (PENDING_SIZE),
            .W    (PENDING_BITS)
        ) u_counter (
            .clk   (clk),
            .reset (reset),
            .inc   (issue_fire && (issue_wid == NW_WIDTH'(g))),
            .dec   (commit_valid && commit_eop && (commit_wid == NW_WIDTH'(g))),
            .count (cnt[g]),
            .full  (cnt_full[g]),
            .one   (cnt_one[g])
        );

        assign warp_state[g] = '{count: cnt[g], locked: locked_q[g]};
    end

    always_comb begin
        issue_ready = !reset && !cnt_full[issue_wid] && !warp_state[issue_wid].locked;
        issue_fire  = issue_valid && issue_ready;
        // No bypass: the CSR unit keeps asking until the registered count drops.
        alm_empty   = !reset && cnt_one[alm_empty_wid];
    end

    always_comb begin
        lock_set = '0;
        lock_clr = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            lock_set[w] = issue_fire && issue_lock && (issue_wid == NW_WIDTH'(w));
            lock_clr[w] = unlock_warp && (unlock_wid == NW_WIDTH'(w));
        end
    end

    // Lock and unlock stage: a same-cycle lock overrides the release.
    always_ff @(posedge clk) begin
        if (reset) begin
            locked_q <= '0;
        end else begin
            locked_q <= (locked_q & ~lock_clr) | lock_set;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_q + CYCLE_WIDTH'(1);
        end
    end

    assign warp_locked = locked_q;
    assign cycles      = cycles_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (commit_valid && commit_eop) begin
                assert (warp_state[commit_wid].count != '0)
                    else $warning("pending count underflow on warp %0d", commit_wid);
            end
            if (unlock_warp) begin
                assert (warp_state[unlock_wid].locked)
                    else $warning("unlock of warp %0d which holds no lock", unlock_wid);
                assert (!(issue_fire && issue_lock && (issue_wid == unlock_wid)))
                    else $warning("lock and unlock collide on warp %0d", unlock_wid);
            end
        end
    end

endmodule

// File: tb/tb_vx_csr_pending_tracker.sv
// Directed bench for vx_csr_pending_tracker with a per-warp counting model
// checked every cycle, plus literal expectations at key points.
module tb_vx_csr_pending_tracker;

    localparam int NW  = 8;
    localparam int NWW = 3;
    localparam int PS  = 16;
    localparam int CW  = 64;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           issue_valid = 1'b0;
    logic           issue_ready;
    logic [NWW-1:0] issue_wid = '0;
    logic           issue_lock = 1'b0;
    logic           commit_valid = 1'b0;
    logic           commit_eop = 1'b0;
    logic [NWW-1:0] commit_wid = '0;
    logic [NWW-1:0] alm_empty_wid = '0;
    logic           alm_empty;
    logic           unlock_warp = 1'b0;
    logic [NWW-1:0] unlock_wid = '0;
    logic [NW-1:0]  warp_locked;
    logic [CW-1:0]  cycles;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    vx_csr_pending_tracker #(
        .NUM_WARPS    (NW),
        .PENDING_SIZE (PS),
        .CYCLE_WIDTH  (CW),
        .NW_WIDTH     (NWW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_wid     (issue_wid),
        .issue_lock    (issue_lock),
        .commit_valid  (commit_valid),
        .commit_eop    (commit_eop),
        .commit_wid    (commit_wid),
        .alm_empty_wid (alm_empty_wid),
        .alm_empty     (alm_empty),
        .unlock_warp   (unlock_warp),
        .unlock_wid    (unlock_wid),
        .warp_locked   (warp_locked),
        .cycles        (cycles)
    );

    always #5 clk = ~clk;

    // Model: plain integer counts per warp, a lock flag per warp, a cycle total.
    int          pend [NW];
    bit          lk   [NW];
    logic [63:0] mcyc = '0;

    initial begin
        for (int w = 0; w < NW; w++) begin
            pend[w] = 0;
            lk[w]   = 1'b0;
        end
    end

    function automatic bit m_ready(input int w);
        return !reset && (pend[w] < PS) && !lk[w];
    endfunction

    function automatic bit m_alm(input int w);
        return !reset && (pend[w] == 1);
    endfunction

    function automatic logic [NW-1:0] m_locked();
        logic [NW-1:0] v;
        for (int w = 0; w < NW; w++) v[w] = lk[w];
        return v;
    endfunction

    always @(posedge clk) begin : model_step
        bit fire;
        int nxt;
        if (reset) begin
            for (int w = 0; w < NW; w++) begin
                pend[w] = 0;
                lk[w]   = 1'b0;
            end
            mcyc = '0;
        end else begin
            fire = issue_valid && m_ready(int'(issue_wid));
            for (int w = 0; w < NW; w++) begin
                nxt = pend[w];
                if (fire && int'(issue_wid) == w) nxt = nxt + 1;
                if (commit_valid && commit_eop && int'(commit_wid) == w) nxt = nxt - 1;
                pend[w] = (nxt < 0) ? 0 : nxt;
            end
            if (unlock_warp) lk[int'(unlock_wid)] = 1'b0;
            if (fire && issue_lock) lk[int'(issue_wid)] = 1'b1;
            mcyc = mcyc + 64'd1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_issue_ready", 64'(issue_ready), 64'(m_ready(int'(issue_wid))));
            chk("model_alm_empty", 64'(alm_empty), 64'(m_alm(int'(alm_empty_wid))));
            chk("model_warp_locked", 64'(warp_locked), 64'(m_locked()));
            chk("model_cycles", cycles, mcyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid  = 1'b0;
        issue_lock   = 1'b0;
        commit_valid = 1'b0;
        commit_eop   = 1'b0;
        unlock_warp  = 1'b0;
    endtask

    task automatic issue_n(input int wid, input int n, input bit lock);
        issue_valid = 1'b1;
        issue_wid   = NWW'(wid);
        issue_lock  = lock;
        repeat (n) tick();
        idle();
    endtask

    task automatic commit_n(input int wid, input int n, input bit eop);
        commit_valid = 1'b1;
        commit_eop   = eop;
        commit_wid   = NWW'(wid);
        repeat (n) tick();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        repeat (2) tick();
        chk("reset_issue_ready", 64'(issue_ready), 64'd0);
        chk("reset_alm_empty", 64'(alm_empty), 64'd0);
        chk("reset_cycles", cycles, 64'd0);
        chk("reset_locked", 64'(warp_locked), 64'd0);
        chk_en = 1'b1;

        reset = 1'b0;
        repeat (10) tick();
        chk("idle_cycles", cycles, 64'd10);
        chk("idle_locked", 64'(warp_locked), 64'd0);
        for (int w = 0; w < NW; w++) begin
            issue_wid = NWW'(w);
            #1;
            chk("idle_issue_ready", 64'(issue_ready), 64'd1);
        end

        alm_empty_wid = 3'd2;
        issue_n(2, 3, 1'b0);
        #1 chk("w2_count3_alm", 64'(alm_empty), 64'd0);
        commit_n(2, 2, 1'b1);
        #1 chk("w2_count1_alm", 64'(alm_empty), 64'd1);

        issue_n(1, 1, 1'b1);
        issue_wid = 3'd1;
        #1;
        chk("w1_locked", 64'(warp_locked), 64'h02);
        chk("w1_locked_ready", 64'(issue_ready), 64'd0);
        unlock_warp = 1'b1;
        unlock_wid  = 3'd1;
        tick();
        idle();
        #1;
        chk("w1_unlocked", 64'(warp_locked), 64'h00);
        chk("w1_unlocked_ready", 64'(issue_ready), 64'd1);

        issue_n(0, PS, 1'b0);
        issue_wid = 3'd0;
        #1 chk("w0_full_ready", 64'(issue_ready), 64'd0);
        issue_wid = 3'd5;
        #1 chk("w5_ready_while_w0_full", 64'(issue_ready), 64'd1);
        issue_valid  = 1'b1;
        issue_wid    = 3'd0;
        commit_valid = 1'b1;
        commit_eop   = 1'b1;
        commit_wid   = 3'd0;
        #1 chk("w0_full_issue_refused", 64'(issue_ready), 64'd0);
        tick();
        idle();
        #1 chk("w0_after_commit_ready", 64'(issue_ready), 64'd1);

        alm_empty_wid = 3'd3;
        issue_n(3, 1, 1'b0);
        #1 chk("w3_count1_alm", 64'(alm_empty), 64'd1);
        commit_n(3, 1, 1'b0);
        #1 chk("w3_no_eop_holds", 64'(alm_empty), 64'd1);
        commit_n(3, 1, 1'b1);
        #1 chk("w3_count0_alm", 64'(alm_empty), 64'd0);
        commit_n(3, 1, 1'b1);
        #1 chk("w3_underflow_alm", 64'(alm_empty), 64'd0);
        issue_n(3, 1, 1'b0);
        #1 chk("w3_underflow_held_zero", 64'(alm_empty), 64'd1);

        alm_empty_wid = 3'd4;
        issue_n(4, 4, 1'b0);
        issue_n(4, 1, 1'b1);
        issue_wid = 3'd4;
        #1;
        chk("w4_locked", 64'(warp_locked), 64'h10);
        chk("w4_count5_alm", 64'(alm_empty), 64'd0);
        reset = 1'b1;
        tick();
        chk("rst_mid_locked", 64'(warp_locked), 64'd0);
        chk("rst_mid_cycles", cycles, 64'd0);
        chk("rst_mid_ready", 64'(issue_ready), 64'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_cycles", cycles, 64'd1);
        chk("post_rst_w4_ready", 64'(issue_ready), 64'd1);
        issue_n(4, 1, 1'b0);
        #1 chk("post_rst_w4_count1", 64'(alm_empty), 64'd1);

        tick();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
